// File: rtl/instr_fetch.sv
// In-order instruction fetch: issues word requests, buffers in-order responses in a
// small FIFO tagged with their PC, and hands them to decode; redirects flush the stream.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  instr_op
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_drop_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_data [DEPTH];
  logic [31:0]   r_fifo_pc   [DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_pop;
  logic          w_rsp_drop;
  logic          w_push;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_drop_next;
  logic [31:0]   w_redirect_pc;
  logic          w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = &{1'b0, redirect_pc[1:0]};

  // Requests are only issued when every in-flight word is guaranteed a FIFO slot.
  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req_valid = (r_state != ST_IDLE) && (w_occupancy < DEPTH_W);
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_pop       = (r_count != '0) && instr_ready;
  assign w_rsp_drop  = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
  assign w_push      = imem_rsp_valid && !w_rsp_drop;
  assign w_out_next  = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

  // On redirect everything still in flight after this cycle is stale.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (redirect_valid) begin
      w_drop_next = w_out_next;
    end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = ST_RUN;
      ST_RUN:   if (redirect_valid && (w_out_next != '0)) w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_drop_next == '0) w_state_next = ST_RUN;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= {RESET_PC[31:2], 2'b00};
      r_rsp_pc      <= {RESET_PC[31:2], 2'b00};
      r_outstanding <= '0;
      r_count       <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (redirect_valid) begin
        r_pc     <= w_redirect_pc;
        r_rsp_pc <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_push)     r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      // No push can happen on a redirect cycle, so aligning rd to wr empties the FIFO.
      if (redirect_valid) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_count != '0);
  assign instr          = instr_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign instr_pc       = instr_valid ? r_fifo_pc[r_rd_ptr] : 32'd0;
  assign instr_op       = instr[6:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (w_occupancy <= DEPTH_W);
      assert (!(imem_rsp_valid && (r_outstanding == '0)));
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- In-order instruction fetch unit; the producer side of the instruction stream that the main decoder consumes.
- Issues word requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers returned words in a small FIFO and presents {instr, instr_pc, instr_op} to the decode stage over a valid/ready handshake.
- Supports PC redirect from branch/jump resolution, with flush of buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; in request order, no backpressure.
- imem_rsp_data  in  32  response instruction word.
- redirect_valid  in  1  redirect fetch stream.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- instr_valid  out  1  decode-side instruction valid.
- instr_ready  in  1  decode stage consumes instruction.
- instr  out  32  instruction word at FIFO head.
- instr_pc  out  32  address of instr.
- instr_op  out  7  instr[6:0], feeds decoder op input.

Behaviour:
- Reset is sampled on clk when low. State after reset: pc=RESET_PC, FIFO count=0, outstanding=0, drop_cnt=0, state=IDLE.
- Output values under reset: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr/instr_pc/instr_op=0.
- FSM:
  - IDLE: exactly one cycle after reset deasserts, then goes to RUN.
  - RUN: normal fetch. On redirect, if in-flight count after this cycle is greater than 0, go to FLUSH; otherwise stay in RUN.
  - FLUSH: discard responses until drop_cnt=0, then go to RUN. A further redirect in FLUSH reloads drop_cnt.
- Request issue:
  - imem_req_valid = (state!=IDLE) && (outstanding + count < DEPTH).
  - imem_req_addr = pc.
  - A request is accepted when valid && ready. On accept: pc <= pc+4 (wraps mod 2^32) and outstanding increments.
  - Addr and valid are stable while valid && !ready, unless redirect_valid is asserted.
  - Requests may be issued in FLUSH state.
- Response handling:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {data, pc_tag} is written into the FIFO. pc_tag comes from an internal queue of issued addresses, or from a response-PC counter that tracks issued order.
- Decode side:
  - instr_valid = (count>0).
  - Outputs come from the FIFO head registers.
  - Pop on instr_valid && instr_ready.
  - A word written to an empty FIFO appears at the outputs on the next cycle (no combinational rsp-to-instr path).
- Redirect (redirect_valid=1), same cycle:
  - A pop handshaking this cycle completes normally.
  - All remaining FIFO entries are flushed (count<=0).
  - pc <= {redirect_pc[31:2],2'b00}.
  - drop_cnt <= outstanding after this cycle's accept and response updates. A request accepted this cycle (old pc) is counted and later dropped; a response arriving this cycle is itself dropped.
  - instr_valid=0 the next cycle.
- Simultaneous events:
  - Push and pop on the same cycle keep count unchanged.
  - Push when FIFO full is impossible by construction; an assertion checks outstanding+count <= DEPTH.
- Counters are $clog2(DEPTH)+1 bits wide; none may underflow. An unexpected response with outstanding=0 is a protocol error, flagged by assertion.
- Latency, 1-cycle memory: first request at cycle 1 after reset release, response at cycle 2, instr_valid at cycle 3. Steady-state throughput is one instruction per cycle with DEPTH>=3.

Test Plan:
- Reset release with imem_req_ready=1 and 1-cycle memory returning addr-tagged words: requests 0x0,0x4,0x8…; instr_valid at cycle 3; instr_pc 0x0,0x4,…, one per cycle.
- Hold instr_ready=0: exactly DEPTH instructions are buffered, imem_req_valid drops to 0, and addr stays 0x10 (RESET_PC=0). Release ready: stream resumes in order with no loss or duplication.
- imem_req_ready=0 for 5 cycles: imem_req_valid=1 with imem_req_addr held at a constant value throughout.
- Redirect to 0x103 with 2 requests outstanding: next request addr is 0x100, both stale responses are dropped, and the first delivered instr_pc is 0x100.
- Redirect in the same cycle as an instr handshake and an imem_rsp_valid: the handshaken instruction counts as consumed, the response is dropped, and instr_valid=0 on the next cycle.
- Reset asserted mid-stream with 3 outstanding: all outputs take reset values; after release, fetch restarts at RESET_PC and no stale responses are delivered (the memory model is also reset).
